// File: rtl/photonic_result_serializer.sv
// Buffers whole result vectors from the final MZI layer in a small FIFO and
// streams them out one lane sample per beat, lane 0 first.
module photonic_result_serializer #(
   parameter int LANES     = 2,
   parameter int PRECISION = 8,
   parameter int DEPTH     = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [LANES*PRECISION-1:0]    data_in,
   input  logic                          valid_in,
   output logic [PRECISION-1:0]          tx_data,
   output logic                          tx_valid,
   input  logic                          tx_ready,
   output logic                          tx_last,
   output logic [$clog2(DEPTH):0]        fifo_count,
   output logic                          overflow,
   input  logic                          clr_ovf,
   output logic [7:0]                    drop_count,
   output logic [0:0]                    state_dbg
);

   localparam int VW = LANES * PRECISION;
   localparam int PW = $clog2(DEPTH);
   localparam int IW = $clog2(LANES);
   localparam logic [PW:0]   FULL     = (PW + 1)'(DEPTH);
   localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [IW-1:0] IDX_ONE  = IW'(1);
   localparam logic [IW-1:0] LAST_IDX = IW'(LANES - 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_SEND = 1'b1;

   // Handshake: a beat transfers on a rising edge where tx_valid && tx_ready.
   // tx_valid never depends on tx_ready in the same cycle, and once raised it
   // stays high with tx_data/tx_last frozen until the beat transfers.

   logic [VW-1:0]        mem_q [DEPTH];
   logic [0:0]           state_q, state_d;
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [PW:0]          count_q, count_d;
   logic [VW-1:0]        shreg_q, shreg_d;
   logic [IW-1:0]        lane_idx_q, lane_idx_d;
   logic [PRECISION-1:0] tx_data_q, tx_data_d;
   logic                 tx_valid_q, tx_valid_d;
   logic                 tx_last_q, tx_last_d;
   logic                 overflow_q, overflow_d;
   logic [7:0]           drop_count_q, drop_count_d;

   logic          push;
   logic          drop;
   logic          pop;
   logic          fire;
   logic [VW-1:0] head;

   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      shreg_d      = shreg_q;
      lane_idx_d   = lane_idx_q;
      tx_data_d    = tx_data_q;
      tx_valid_d   = tx_valid_q;
      tx_last_d    = tx_last_q;
      overflow_d   = overflow_q;
      drop_count_d = drop_count_q;
      pop          = 1'b0;
      head         = mem_q[rd_ptr_q];

      // Full is judged on the start-of-cycle count, so a same-cycle pop does not rescue it.
      push = valid_in && (count_q != FULL);
      drop = valid_in && (count_q == FULL);
      fire = tx_valid_q && tx_ready;

      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               pop = 1'b1;
            end
         end
         S_SEND: begin
            if (fire) begin
               if (tx_last_q) begin
                  if (count_q != '0) begin
                     pop = 1'b1;
                  end else begin
                     state_d    = S_IDLE;
                     tx_valid_d = 1'b0;
                     tx_last_d  = 1'b0;
                  end
               end else begin
                  tx_data_d  = shreg_q[PRECISION-1:0];
                  shreg_d    = shreg_q >> PRECISION;
                  lane_idx_d = lane_idx_q + IDX_ONE;
                  tx_last_d  = ((lane_idx_q + IDX_ONE) == LAST_IDX);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (pop) begin
         state_d    = S_SEND;
         tx_data_d  = head[PRECISION-1:0];
         shreg_d    = head >> PRECISION;
         lane_idx_d = '0;
         tx_last_d  = 1'b0;
         tx_valid_d = 1'b1;
         rd_ptr_d   = rd_ptr_q + PTR_ONE;
      end

      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end

      count_d = count_q + (push ? CNT_ONE : '0) - (pop ? CNT_ONE : '0);

      // Clear wins over a simultaneous drop; the drop is still counted.
      if (clr_ovf) begin
         overflow_d = 1'b0;
      end else if (drop) begin
         overflow_d = 1'b1;
      end
      if (drop && (drop_count_q != 8'hFF)) begin
         drop_count_d = drop_count_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         shreg_q      <= '0;
         lane_idx_q   <= '0;
         tx_data_q    <= '0;
         tx_valid_q   <= 1'b0;
         tx_last_q    <= 1'b0;
         overflow_q   <= 1'b0;
         drop_count_q <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         shreg_q      <= shreg_d;
         lane_idx_q   <= lane_idx_d;
         tx_data_q    <= tx_data_d;
         tx_valid_q   <= tx_valid_d;
         tx_last_q    <= tx_last_d;
         overflow_q   <= overflow_d;
         drop_count_q <= drop_count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem_q[wr_ptr_q] <= data_in;
      end
   end

   assign tx_data    = tx_data_q;
   assign tx_valid   = tx_valid_q;
   assign tx_last    = tx_last_q;
   assign fifo_count = count_q;
   assign overflow   = overflow_q;
   assign drop_count = drop_count_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_photonic_result_serializer.sv
// Directed bench for photonic_result_serializer (LANES=2, PRECISION=8, DEPTH=4):
// hand-computed vectors plus a beat scoreboard fed from an expected queue.
module tb_photonic_result_serializer;

   logic        clk;
   logic        rst;
   logic [15:0] data_in;
   logic        valid_in;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        tx_last;
   logic [2:0]  fifo_count;
   logic        overflow;
   logic        clr_ovf;
   logic [7:0]  drop_count;
   logic [0:0]  state_dbg;

   int n_vec = 0;
   int n_err = 0;
   logic [8:0] exp_q[$];

   photonic_result_serializer #(.LANES(2), .PRECISION(8), .DEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .valid_in   (valid_in),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .tx_last    (tx_last),
      .fifo_count (fifo_count),
      .overflow   (overflow),
      .clr_ovf    (clr_ovf),
      .drop_count (drop_count),
      .state_dbg  (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // drives one vector for the coming edge; queues its lanes when it should be delivered
   task automatic drive_vec(input logic [15:0] v, input bit expect_it);
      data_in  = v;
      valid_in = 1'b1;
      if (expect_it) begin
         exp_q.push_back({1'b0, v[7:0]});
         exp_q.push_back({1'b1, v[15:8]});
      end
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (!(tx_valid == 1'b0 && fifo_count == 3'd0 && exp_q.size() == 0) && n < budget) begin
         step();
         n++;
      end
      check_val("drain_done", 32'(n < budget), 32'd1);
   endtask

   // scoreboard: every accepted beat must match the head of the expected queue
   always @(negedge clk) begin
      if (!rst && tx_valid && tx_ready) begin
         if (exp_q.size() == 0) begin
            check_val("unexpected_beat", 32'(exp_q.size()), 32'd1);
         end else begin
            check_val("beat", 32'({tx_last, tx_data}), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      rst      = 1'b1;
      data_in  = '0;
      valid_in = 1'b0;
      tx_ready = 1'b1;
      clr_ovf  = 1'b0;
      step();
      step();
      check_val("rst_valid", 32'(tx_valid), 32'd0);
      check_val("rst_last",  32'(tx_last), 32'd0);
      check_val("rst_data",  32'(tx_data), 32'd0);
      check_val("rst_count", 32'(fifo_count), 32'd0);
      check_val("rst_ovf",   32'(overflow), 32'd0);
      check_val("rst_drops", 32'(drop_count), 32'd0);
      check_val("rst_state", 32'(state_dbg), 32'd0);
      rst = 1'b0;
      step();

      // single vector, latency two cycles
      drive_vec(16'hB2A1, 1'b1);
      step();
      valid_in = 1'b0;
      check_val("s1_count_t1", 32'(fifo_count), 32'd1);
      check_val("s1_valid_t1", 32'(tx_valid), 32'd0);
      step();
      check_val("s1_valid_t2", 32'(tx_valid), 32'd1);
      check_val("s1_data_t2",  32'(tx_data), 32'hA1);
      check_val("s1_last_t2",  32'(tx_last), 32'd0);
      check_val("s1_state_t2", 32'(state_dbg), 32'd1);
      step();
      check_val("s1_data_t3",  32'(tx_data), 32'hB2);
      check_val("s1_last_t3",  32'(tx_last), 32'd1);
      step();
      check_val("s1_valid_t4", 32'(tx_valid), 32'd0);
      wait_idle(10);

      // stall: outputs frozen while tx_ready is low
      tx_ready = 1'b0;
      drive_vec(16'h4433, 1'b1);
      step();
      valid_in = 1'b0;
      step();
      for (int i = 0; i < 10; i++) begin
         check_val("s2_hold_valid", 32'(tx_valid), 32'd1);
         check_val("s2_hold_data",  32'(tx_data), 32'h33);
         check_val("s2_hold_last",  32'(tx_last), 32'd0);
         step();
      end
      tx_ready = 1'b1;
      step();
      check_val("s2_data_l1", 32'(tx_data), 32'h44);
      check_val("s2_last_l1", 32'(tx_last), 32'd1);
      step();
      check_val("s2_valid_end", 32'(tx_valid), 32'd0);
      wait_idle(10);

      // overflow: one sending, four stored, sixth dropped
      tx_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         drive_vec({8'h10 + 8'(i), 8'h20 + 8'(i)}, i < 5);
         step();
      end
      valid_in = 1'b0;
      check_val("s3_count", 32'(fifo_count), 32'd4);
      check_val("s3_ovf",   32'(overflow), 32'd1);
      check_val("s3_drops", 32'(drop_count), 32'd1);
      check_val("s3_valid", 32'(tx_valid), 32'd1);
      check_val("s3_head",  32'(tx_data), 32'h20);
      tx_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         check_val("s3_no_gap", 32'(tx_valid), 32'd1);
         check_val("s3_last_pattern", 32'(tx_last), 32'(i % 2));
         step();
      end
      check_val("s3_valid_end", 32'(tx_valid), 32'd0);
      wait_idle(10);

      // back-to-back pushes with ready high: no bubbles
      drive_vec(16'hA0A1, 1'b1);
      step();
      drive_vec(16'hB0B1, 1'b1);
      step();
      check_val("s4_valid_c2", 32'(tx_valid), 32'd1);
      check_val("s4_last_c2",  32'(tx_last), 32'd0);
      drive_vec(16'hC0C1, 1'b1);
      step();
      valid_in = 1'b0;
      for (int i = 1; i < 6; i++) begin
         check_val("s4_no_gap", 32'(tx_valid), 32'd1);
         check_val("s4_last_pattern", 32'(tx_last), 32'(i % 2));
         step();
      end
      check_val("s4_valid_end", 32'(tx_valid), 32'd0);
      wait_idle(10);

      // reset mid-vector after lane 0 accepted
      drive_vec(16'h6655, 1'b1);
      step();
      valid_in = 1'b0;
      step();
      check_val("s5_lane0", 32'(tx_data), 32'h55);
      step();
      check_val("s5_lane1", 32'(tx_data), 32'h66);
      exp_q.delete();
      rst = 1'b1;
      data_in  = 16'hDEAD;
      valid_in = 1'b1;
      step();
      rst = 1'b0;
      valid_in = 1'b0;
      check_val("s5_valid", 32'(tx_valid), 32'd0);
      check_val("s5_count", 32'(fifo_count), 32'd0);
      check_val("s5_last",  32'(tx_last), 32'd0);
      check_val("s5_state", 32'(state_dbg), 32'd0);
      step();
      check_val("s5_ignored_push", 32'(fifo_count), 32'd0);
      drive_vec(16'h8877, 1'b1);
      step();
      valid_in = 1'b0;
      step();
      check_val("s5_fresh_valid", 32'(tx_valid), 32'd1);
      check_val("s5_fresh_data",  32'(tx_data), 32'h77);
      wait_idle(10);

      // drop counting, clear precedence, saturation
      tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive_vec({8'h50 + 8'(i), 8'h60 + 8'(i)}, 1'b1);
         step();
      end
      valid_in = 1'b0;
      check_val("s6_full",  32'(fifo_count), 32'd4);
      check_val("s6_ovf0",  32'(overflow), 32'd0);
      check_val("s6_drop0", 32'(drop_count), 32'd0);
      drive_vec(16'hEEEE, 1'b0);
      clr_ovf = 1'b1;
      step();
      check_val("s6_clr_ovf",  32'(overflow), 32'd0);
      check_val("s6_clr_drop", 32'(drop_count), 32'd1);
      check_val("s6_clr_count", 32'(fifo_count), 32'd4);
      clr_ovf = 1'b0;
      step();
      check_val("s6_set_ovf",  32'(overflow), 32'd1);
      check_val("s6_set_drop", 32'(drop_count), 32'd2);
      valid_in = 1'b0;
      clr_ovf  = 1'b1;
      step();
      clr_ovf = 1'b0;
      check_val("s6_cleared", 32'(overflow), 32'd0);
      check_val("s6_kept",    32'(drop_count), 32'd2);
      valid_in = 1'b1;
      for (int i = 0; i < 300; i++) begin
         step();
      end
      valid_in = 1'b0;
      check_val("s6_saturate", 32'(drop_count), 32'd255);
      check_val("s6_ovf_sat",  32'(overflow), 32'd1);
      tx_ready = 1'b1;
      wait_idle(40);
      check_val("s6_empty", 32'(fifo_count), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
